// File: rtl/freq_meter.sv
// Gated-window frequency meter: counts synchronized rising edges of sig_in over
// GATE_CYCLES clocks and latches the total as packed BCD once per window.
module freq_meter #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int DIGITS      = 6
) (
  input  logic                  BoardCLK,
  input  logic                  rst_n,
  input  logic                  sig_in,
  output logic [4*DIGITS-1:0]   freq_bcd,
  output logic                  overflow,
  output logic                  valid,
  output logic                  gate
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int BW = 4 * DIGITS;

  if (GATE_CYCLES < 4 || DIGITS < 1 || DIGITS > 8 || CLK_HZ < 4) begin : g_bad_param
    $error("freq_meter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_GATE  = 2'd0,
    S_LATCH = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_s1;
  logic            r_s2;
  logic            r_s3;
  logic            w_rise;
  logic [GW-1:0]   r_g;
  logic [GW-1:0]   w_g_next;
  logic [BW-1:0]   r_count;
  logic [BW-1:0]   w_count_next;
  logic            r_ovf;
  logic            w_ovf_next;
  logic [BW-1:0]   r_freq_bcd;
  logic [BW-1:0]   w_freq_next;
  logic            r_overflow;
  logic            w_overflow_next;
  logic            r_valid;
  logic            w_valid_next;
  logic            r_gate;

  // Decimal increment with per-digit carry; 9 rolls to 0 and carries upward.
  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] res;
    logic          carry;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          res[4*i +: 4] = 4'd0;
          carry         = 1'b1;
        end else begin
          res[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end else begin
        res[4*i +: 4] = v[4*i +: 4];
      end
    end
    return res;
  endfunction

  function automatic logic all_nines(input logic [BW-1:0] v);
    logic res;
    res = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      res = res & (v[4*i +: 4] == 4'd9);
    end
    return res;
  endfunction

  assign w_rise = r_s2 & ~r_s3;

  // Three-flop synchronizer; only r_s1 samples the asynchronous input.
  always_ff @(posedge BoardCLK or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // FSM state register.
  always_ff @(posedge BoardCLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_GATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath decode for the gate/latch/clear cycle.
  always_comb begin
    w_state_next    = r_state;
    w_g_next        = r_g;
    w_count_next    = r_count;
    w_ovf_next      = r_ovf;
    w_freq_next     = r_freq_bcd;
    w_overflow_next = r_overflow;
    w_valid_next    = 1'b0;
    case (r_state)
      S_GATE: begin
        w_g_next = r_g + GW'(1);
        if (w_rise) begin
          // Saturate at all nines rather than wrap, and flag it for the window.
          if (all_nines(r_count)) begin
            w_ovf_next = 1'b1;
          end else begin
            w_count_next = bcd_inc(r_count);
          end
        end else begin
          w_count_next = r_count;
        end
        if (r_g == GW'(GATE_CYCLES - 1)) begin
          w_state_next = S_LATCH;
        end else begin
          w_state_next = S_GATE;
        end
      end
      S_LATCH: begin
        w_freq_next     = r_count;
        w_overflow_next = r_ovf;
        w_valid_next    = 1'b1;
        w_state_next    = S_CLEAR;
      end
      S_CLEAR: begin
        w_count_next = {BW{1'b0}};
        w_ovf_next   = 1'b0;
        w_g_next     = {GW{1'b0}};
        w_state_next = S_GATE;
      end
      default: begin
        w_count_next = {BW{1'b0}};
        w_ovf_next   = 1'b0;
        w_g_next     = {GW{1'b0}};
        w_state_next = S_GATE;
      end
    endcase
  end

  // Window counters and registered outputs.
  always_ff @(posedge BoardCLK or negedge rst_n) begin
    if (!rst_n) begin
      r_g        <= {GW{1'b0}};
      r_count    <= {BW{1'b0}};
      r_ovf      <= 1'b0;
      r_freq_bcd <= {BW{1'b0}};
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
      r_gate     <= 1'b0;
    end else begin
      r_g        <= w_g_next;
      r_count    <= w_count_next;
      r_ovf      <= w_ovf_next;
      r_freq_bcd <= w_freq_next;
      r_overflow <= w_overflow_next;
      r_valid    <= w_valid_next;
      r_gate     <= (w_state_next == S_GATE);
    end
  end

  assign freq_bcd = r_freq_bcd;
  assign overflow = r_overflow;
  assign valid    = r_valid;
  assign gate     = r_gate;

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated-window frequency meter for the lab board. It counts rising edges of an external, asynchronous input signal over a fixed gate window derived from `BoardCLK`, and presents the result as packed BCD digits ready for the seven-segment scan path. It is the measuring counterpart to the board clock divider: the divider produces known frequencies, and this block reads a frequency back. Results refresh continuously, once per gate window.

## Interface
- `CLK_HZ`, default 50_000_000: `BoardCLK` frequency, in Hz.
- `GATE_CYCLES`, default 50_000_000: gate window length in `BoardCLK` cycles. The default gives a 1 s window, so the count reads directly in Hz. Legal range is 4 or more.
- `DIGITS`, default 6: number of BCD digits in the result. Legal range is 1 to 8.

- `BoardCLK`, input, 1 bit: the single clock; all state changes on its rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `sig_in`, input, 1 bit: signal under measurement. It is asynchronous to `BoardCLK`.
- `freq_bcd`, output, 4*`DIGITS` bits: latched result in packed BCD, least significant digit in bits [3:0].
- `overflow`, output, 1 bit: set when the latched result saturated.
- `valid`, output, 1 bit: one-cycle pulse marking that a new result has been latched.
- `gate`, output, 1 bit: high while edges are being counted.

## Operation
- **Input synchronizer:** `sig_in` passes through a 3-flop chain `s1`→`s2`→`s3`. A rising edge is `rise = s2 & ~s3`. No other logic samples `sig_in`.
- **FSM states:** GATE, LATCH, CLEAR. Reset enters GATE with gate counter `g` = 0, edge count 0 and the saturation flag `ovf` = 0.
- **GATE state:**
  - `g` increments by 1 every cycle.
  - When `rise` = 1 the BCD count increments with per-digit carry, where 9 rolls to 0 and carries into the next digit.
  - If the count is all 9s and `rise` = 1, the count holds at all 9s and `ovf` is set to 1. `ovf` is sticky for the rest of the window.
  - When `g` = `GATE_CYCLES`-1, the next state is LATCH.
- **LATCH state:** lasts 1 cycle. `freq_bcd` is loaded with the count and `overflow` with `ovf`, and `valid` is registered high. The next state is CLEAR.
- **CLEAR state:** lasts 1 cycle. The count, `ovf` and `g` are cleared, `valid` returns low, and the next state is GATE.
- **Edges outside GATE:** a `rise` during LATCH or CLEAR is dropped. The dead time is 2 cycles per window.
- **Output behaviour:**
  - `gate` is 1 exactly while the state is GATE.
  - `freq_bcd` and `overflow` hold their values between LATCH events.
  - The count never exceeds 10^`DIGITS` − 1.
- **Reset behaviour:**
  - Reset values: `freq_bcd` = 0, `overflow` = 0, `valid` = 0, `gate` = 0 while `rst_n` is low, and synchronizer flops = 0.
  - Reset asserted in any state aborts the window immediately with no partial latch.
  - After deassertion the block restarts at GATE with `g` = 0.

## Timing
- Cycle 1 is the first `BoardCLK` rising edge with `rst_n` high.
  - GATE covers cycles 1..`GATE_CYCLES`; `gate` is high after edge 1.
  - LATCH is cycle `GATE_CYCLES`+1; `valid` and the new `freq_bcd` are visible after that edge.
  - `valid` falls after edge `GATE_CYCLES`+2.
- The measurement period is `GATE_CYCLES`+2 cycles, so `valid` pulses exactly every `GATE_CYCLES`+2 cycles.
- **Edge latency:** a `sig_in` rise registers in the count 3 to 4 cycles later (2 flops plus the detect stage, plus up to 1 cycle of sampling phase).
  - An edge in the last 3 cycles of a window may be credited to the next window.
  - The result is exact to ±1 count.
- **Input constraints:**
  - `sig_in` must be high for at least 2 cycles and low for at least 2 cycles to be counted reliably.
  - The maximum measurable frequency is `CLK_HZ`/4.
  - Narrower pulses may be missed but must never be double-counted.
- **Pipelining:** one `rise` yields at most one increment, and the increment is single-cycle, with no back-to-back hazard.

## Test plan
- **Reset:**
  - Stimulus: drive `rst_n` = 0 with `sig_in` toggling.
  - Required response: `freq_bcd` = 0, `overflow` = 0, `valid` = 0 and `gate` = 0 throughout.
  - After release with `GATE_CYCLES`=1000: the first `valid` pulse is after edge 1001, lasts 1 cycle, and the next pulse is after edge 2003.
- **Known rate:**
  - Stimulus: `GATE_CYCLES`=1000, `sig_in` period of 10 clocks (5 high, 5 low), held steady.
  - Required response: `freq_bcd` is `24'h000100`, or `24'h000099`/`24'h000101`, on every window.
  - `overflow` stays 0 and the result holds between `valid` pulses.
- **DC input:**
  - Stimulus: `sig_in` held at 1, then at 0, for 3 windows.
  - Required response: `freq_bcd` = `24'h000000` on each `valid`.
- **Saturation:**
  - Stimulus: `DIGITS`=2, `GATE_CYCLES`=1000, `sig_in` period of 4 clocks (250 edges).
  - Required response: `freq_bcd` = `8'h99` and `overflow` = 1.
  - Then switch to a period of 20 clocks. Required response: the next window reads `8'h50`±1 with `overflow` = 0.
- **Reset mid-window:**
  - Stimulus: `GATE_CYCLES`=1000, `sig_in` period of 10 clocks, `rst_n` pulsed low at cycle 500.
  - Required response: no `valid` pulse from the aborted window, and outputs return to 0.
  - The next `valid` arrives 1001 cycles after release, with `freq_bcd` of 100±1.
- **Rate change and dead time:**
  - Stimulus: switch the `sig_in` period from 10 to 8 clocks mid-window.
  - Required response: that window reads between 100 and 125, and the following window reads 125±1.
  - A single 2-cycle pulse placed only during LATCH/CLEAR is not counted.
